mpu_cmd_sched: RTL and testbench
================================

# mpu_cmd_sched

Command scheduler between the Ethernet receive decoder and the MPU core. It queues decoded LOAD and MULTIPLY commands in order and checks each one against a per-buffer "loaded" scoreboard. Legal commands are issued to the MPU one at a time, only when the MPU reports ready. Illegal commands are dropped and reported with an error pulse, so the transmit path can raise a command-error frame.

## Interface
Parameters:
- BUFFER_CNT, 4 — number of A and number of B buffer slots; legal index range is 0..BUFFER_CNT-1; at most 32.
- QUEUE_DEPTH, 4 — command FIFO entries; must be a power of two and at least 2.
- BIAS_W, 24 — bias width.

Ports:
- clk  in  1  — clock; all logic is on the rising edge.
- rst  in  1  — synchronous, active-high reset.
- in_valid  in  1  — decoder presents a command.
- in_ready  out  1  — FIFO can accept a command; equals !full.
- in_op  in  1  — 0 = LOAD, 1 = MULTIPLY.
- in_buffer_a_b  in  1  — LOAD target: 0 = A, 1 = B.
- in_a_idx, in_b_idx  in  5 each  — buffer indices.
- in_bias  in  BIAS_W  — signed bias for MULTIPLY.
- in_activation, in_pooling  in  8 each  — MULTIPLY options.
- load, multiply  out  1 each  — single-cycle issue strobes to the MPU.
- buffer_a_b, buffer_a_idx, buffer_b_idx, bias, activation, pooling  out  —  fields of the issued command; widths match the in_* fields.
- mpu_ready  in  1  — MPU idle and able to accept a command.
- invalidate  in  1  — clears all scoreboard bits.
- cmd_error  out  1  — one-cycle pulse when a command is dropped.
- err_code  out  2  — 01 = index out of range, 10 = buffer not loaded; held until the next error.
- busy  out  1  — FSM is not in IDLE, or the FIFO is non-empty.
- queue_level  out  $clog2(QUEUE_DEPTH)+1  — current FIFO occupancy.

## Operation
- **FIFO.** A push occurs when in_valid && in_ready; all command fields are captured. There is no bypass: a pushed command reaches the head no earlier than the next cycle. A pop occurs only on issue or drop.
- **Scoreboard.** Two bit vectors, loaded_a[BUFFER_CNT] and loaded_b[BUFFER_CNT].
  - Issuing a LOAD sets the bit selected by (buffer_a_b, idx).
  - invalidate clears all bits.
  - If invalidate and a LOAD issue occur in the same cycle, the LOAD's bit ends up set.
- **Head check** (combinational on the FIFO head):
  - LOAD: the relevant index (a_idx for A, b_idx for B) must be less than BUFFER_CNT; otherwise err 01.
  - MULTIPLY: both indices must be less than BUFFER_CNT (else err 01), and loaded_a[a_idx] && loaded_b[b_idx] must hold (else err 10).
- **FSM states:**
  - IDLE, FIFO empty: stay in IDLE.
  - IDLE, head fails check: pop, pulse cmd_error, update err_code, stay in IDLE. This costs one cycle per dropped command; mpu_ready is not required.
  - IDLE, head passes check and mpu_ready=1: register the command fields onto the outputs, pulse load or multiply, pop, go to WAIT_LOW.
  - IDLE, head passes check and mpu_ready=0: stay in IDLE.
  - WAIT_LOW: go to WAIT_HIGH when mpu_ready=0.
  - WAIT_HIGH: go to IDLE when mpu_ready=1.
- **MPU contract.** The MPU drops mpu_ready within 2 cycles of a strobe and keeps it low for at least one cycle.
- **Output hold.** Command fields stay stable from the issue cycle until the next issue. On a LOAD issue, the idx field for the buffer not being loaded is driven to 0.
- **Ordering.** Commands are processed strictly in order. A LOAD queued ahead of a MULTIPLY is always issued, and its scoreboard bit set, before the MULTIPLY is checked.

## Timing
- **Reset values:** all outputs 0 except in_ready=1. FIFO empty, scoreboard clear, FSM in IDLE.
- **Reset mid-operation:** reset takes effect on the next edge. Queued and in-flight commands are discarded; no strobe or error pulse follows the reset edge.
- **Issue latency:** a command pushed at edge N, with mpu_ready=1 and an empty FIFO, has its strobe asserted in cycle N+1 (visible after edge N+1).
- **Drop latency:** a failing command at the head produces cmd_error in the cycle after it reaches the head.
- **Throughput:** at most one issue per MPU busy cycle (IDLE → WAIT_LOW → WAIT_HIGH → IDLE); at most one drop per cycle.
- **FIFO full:** in_ready=0 and in_valid is ignored. A pop and a push attempted in the same cycle while full: the push is refused (in_ready is already low).
- **Index wrap:** FIFO pointers wrap modulo QUEUE_DEPTH; queue_level is exact for every occupancy from 0 to QUEUE_DEPTH.
- **Strobes:** load and multiply are never high in the same cycle, and never high for two consecutive cycles.

## Test plan
- LOAD A idx1, LOAD B idx2, MULTIPLY(1,2, bias=-5, act=1, pool=1), with mpu_ready toggled as specified → three strobes in order. MULTIPLY outputs show a_idx=1, b_idx=2, bias=-5; cmd_error stays 0.
- MULTIPLY(0,0) after reset → no strobe; cmd_error pulses once with err_code=10; the FIFO drains to 0.
- LOAD A idx=BUFFER_CNT → cmd_error with err_code=01; loaded_a unchanged. A following MULTIPLY using that index is also dropped.
- mpu_ready held 0 while 5 commands are pushed with QUEUE_DEPTH=4 → in_ready drops after 4 and queue_level=4. On releasing mpu_ready → all 4 issue in order; the 5th is accepted once space frees.
- LOAD A0, LOAD B0, assert invalidate, then MULTIPLY(0,0) → the MULTIPLY is dropped with err 10. Invalidate coincident with a LOAD A3 issue → loaded_a[3]=1 afterwards.
- Reset asserted in WAIT_LOW with 2 commands queued → the next cycle shows all outputs at reset values and queue_level=0. No strobe appears when mpu_ready later rises.

Source files
------------

// File: rtl/mpu_cmd_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : mpu_cmd_sched_if
// Brief    : Command, issue and status signals between decoder, scheduler, MPU.
// Revision : 1.0
// ============================================================================
interface mpu_cmd_sched_if #(
    parameter int BIAS_W      = 24,
    parameter int QUEUE_DEPTH = 4
);
    localparam int LVL_W = $clog2(QUEUE_DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic              in_op;
    logic              in_buffer_a_b;
    logic [4:0]        in_a_idx;
    logic [4:0]        in_b_idx;
    logic [BIAS_W-1:0] in_bias;
    logic [7:0]        in_activation;
    logic [7:0]        in_pooling;

    logic              load;
    logic              multiply;
    logic              buffer_a_b;
    logic [4:0]        buffer_a_idx;
    logic [4:0]        buffer_b_idx;
    logic [BIAS_W-1:0] bias;
    logic [7:0]        activation;
    logic [7:0]        pooling;
    logic              mpu_ready;

    logic              invalidate;
    logic              cmd_error;
    logic [1:0]        err_code;
    logic              busy;
    logic [LVL_W-1:0]  queue_level;

    modport slave (
        input  in_valid, in_op, in_buffer_a_b, in_a_idx, in_b_idx, in_bias,
               in_activation, in_pooling, mpu_ready, invalidate,
        output in_ready, load, multiply, buffer_a_b, buffer_a_idx, buffer_b_idx,
               bias, activation, pooling, cmd_error, err_code, busy, queue_level
    );

    modport master (
        output in_valid, in_op, in_buffer_a_b, in_a_idx, in_b_idx, in_bias,
               in_activation, in_pooling, mpu_ready, invalidate,
        input  in_ready, load, multiply, buffer_a_b, buffer_a_idx, buffer_b_idx,
               bias, activation, pooling, cmd_error, err_code, busy, queue_level
    );
endinterface
`default_nettype wire

// File: rtl/mpu_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : mpu_cmd_sched
// Brief    : In-order LOAD/MULTIPLY command queue with loaded-buffer scoreboard.
// Revision : 1.0
// ============================================================================
module mpu_cmd_sched #(
    parameter int BUFFER_CNT  = 4,
    parameter int QUEUE_DEPTH = 4,
    parameter int BIAS_W      = 24
) (
    input  logic            clk,
    input  logic            rst,
    mpu_cmd_sched_if.slave  bus
);
    localparam int         PTR_W       = $clog2(QUEUE_DEPTH);
    localparam int         LVL_W       = PTR_W + 1;
    localparam logic [5:0] c_BUF_LIMIT = 6'(BUFFER_CNT);

    typedef struct packed {
        logic              op;
        logic              ab;
        logic [4:0]        a_idx;
        logic [4:0]        b_idx;
        logic [BIAS_W-1:0] bias;
        logic [7:0]        act;
        logic [7:0]        pool;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LOW  = 2'd1,
        S_WAIT_HIGH = 2'd2
    } state_t;

    cmd_t              r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_count;

    state_t            r_state;
    logic [31:0]       r_loaded_a;
    logic [31:0]       r_loaded_b;
    logic              r_load;
    logic              r_multiply;
    logic              r_buffer_a_b;
    logic [4:0]        r_buffer_a_idx;
    logic [4:0]        r_buffer_b_idx;
    logic [BIAS_W-1:0] r_bias;
    logic [7:0]        r_activation;
    logic [7:0]        r_pooling;
    logic              r_cmd_error;
    logic [1:0]        r_err_code;

    cmd_t              w_in_cmd;
    cmd_t              w_head;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic              w_drop;
    logic [4:0]        w_load_idx;
    logic [1:0]        w_err;

    function automatic logic idx_ok(input logic [4:0] idx);
        return ({1'b0, idx} < c_BUF_LIMIT);
    endfunction

    assign w_in_cmd = '{op: bus.in_op, ab: bus.in_buffer_a_b, a_idx: bus.in_a_idx,
                        b_idx: bus.in_b_idx, bias: bus.in_bias,
                        act: bus.in_activation, pool: bus.in_pooling};
    assign w_head   = r_mem[r_rd_ptr];
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == LVL_W'(QUEUE_DEPTH));
    assign w_push   = bus.in_valid && !w_full;

    // Head legality; scoreboard vectors are 32 wide so any 5-bit index is a safe read
    always_comb begin
        w_err      = 2'b00;
        w_load_idx = w_head.ab ? w_head.b_idx : w_head.a_idx;
        if (!w_head.op) begin
            if (!idx_ok(w_load_idx)) w_err = 2'b01;
        end else if (!idx_ok(w_head.a_idx) || !idx_ok(w_head.b_idx)) begin
            w_err = 2'b01;
        end else if (!(r_loaded_a[w_head.a_idx] && r_loaded_b[w_head.b_idx])) begin
            w_err = 2'b10;
        end
    end

    assign w_drop  = (r_state == S_IDLE) && !w_empty && (w_err != 2'b00);
    assign w_issue = (r_state == S_IDLE) && !w_empty && (w_err == 2'b00) && bus.mpu_ready;
    assign w_pop   = w_drop || w_issue;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in_cmd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_loaded_a     <= '0;
            r_loaded_b     <= '0;
            r_load         <= 1'b0;
            r_multiply     <= 1'b0;
            r_buffer_a_b   <= 1'b0;
            r_buffer_a_idx <= '0;
            r_buffer_b_idx <= '0;
            r_bias         <= '0;
            r_activation   <= '0;
            r_pooling      <= '0;
            r_cmd_error    <= 1'b0;
            r_err_code     <= 2'b00;
        end else begin
            r_load      <= 1'b0;
            r_multiply  <= 1'b0;
            r_cmd_error <= 1'b0;
            // The clear comes first so a same-cycle LOAD issue wins its bit
            if (bus.invalidate) begin
                r_loaded_a <= '0;
                r_loaded_b <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_drop) begin
                        r_cmd_error <= 1'b1;
                        r_err_code  <= w_err;
                    end else if (w_issue) begin
                        r_load         <= !w_head.op;
                        r_multiply     <= w_head.op;
                        r_buffer_a_b   <= w_head.ab;
                        r_buffer_a_idx <= (!w_head.op && w_head.ab)  ? 5'd0 : w_head.a_idx;
                        r_buffer_b_idx <= (!w_head.op && !w_head.ab) ? 5'd0 : w_head.b_idx;
                        r_bias         <= w_head.bias;
                        r_activation   <= w_head.act;
                        r_pooling      <= w_head.pool;
                        if (!w_head.op) begin
                            if (w_head.ab) r_loaded_b[w_head.b_idx] <= 1'b1;
                            else           r_loaded_a[w_head.a_idx] <= 1'b1;
                        end
                        r_state <= S_WAIT_LOW;
                    end
                end
                S_WAIT_LOW:  if (!bus.mpu_ready) r_state <= S_WAIT_HIGH;
                S_WAIT_HIGH: if (bus.mpu_ready)  r_state <= S_IDLE;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = !w_full;
    assign bus.load         = r_load;
    assign bus.multiply     = r_multiply;
    assign bus.buffer_a_b   = r_buffer_a_b;
    assign bus.buffer_a_idx = r_buffer_a_idx;
    assign bus.buffer_b_idx = r_buffer_b_idx;
    assign bus.bias         = r_bias;
    assign bus.activation   = r_activation;
    assign bus.pooling      = r_pooling;
    assign bus.cmd_error    = r_cmd_error;
    assign bus.err_code     = r_err_code;
    assign bus.busy         = (r_state != S_IDLE) || !w_empty;
    assign bus.queue_level  = r_count;
endmodule
`default_nettype wire

// File: tb/tb_mpu_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpu_cmd_sched
// Brief    : Directed and random stimulus against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_mpu_cmd_sched;
    localparam int BUF = 4;
    localparam int QD  = 4;
    localparam int BW  = 24;

    typedef struct {
        bit          op;
        bit          ab;
        bit [4:0]    a;
        bit [4:0]    b;
        bit [BW-1:0] bias;
        bit [7:0]    act;
        bit [7:0]    pool;
    } tcmd_t;

    typedef struct packed {
        logic [1:0]    kind;
        logic          ab;
        logic [4:0]    a;
        logic [4:0]    b;
        logic [BW-1:0] bias;
        logic [7:0]    act;
        logic [7:0]    pool;
        logic [1:0]    err;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic auto_mpu = 1'b1;
    logic mpu_auto_rdy = 1'b1;
    logic mpu_man = 1'b1;
    logic prev_strobe = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   m_la [32];
    bit   m_lb [32];
    ev_t  exp_q [$];
    ev_t  got_q [$];

    mpu_cmd_sched_if #(.BIAS_W(BW), .QUEUE_DEPTH(QD)) bus ();

    mpu_cmd_sched #(.BUFFER_CNT(BUF), .QUEUE_DEPTH(QD), .BIAS_W(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mpu_ready = auto_mpu ? mpu_auto_rdy : mpu_man;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic tcmd_t mk(bit op, bit ab, int a, int b, int bias, int act, int pool);
        tcmd_t c;
        c.op = op; c.ab = ab; c.a = 5'(a); c.b = 5'(b);
        c.bias = BW'(bias); c.act = 8'(act); c.pool = 8'(pool);
        return c;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_la[i] = 1'b0;
            m_lb[i] = 1'b0;
        end
    endfunction

    // Expected outcome of a command, evaluated in queue order against the model scoreboard
    function automatic void model_accept(tcmd_t c);
        ev_t e = '0;
        int  idx = c.ab ? int'(c.b) : int'(c.a);
        if (!c.op && idx >= BUF) begin
            e.kind = 2'd2; e.err = 2'b01;
        end else if (c.op && (int'(c.a) >= BUF || int'(c.b) >= BUF)) begin
            e.kind = 2'd2; e.err = 2'b01;
        end else if (c.op && !(m_la[c.a] && m_lb[c.b])) begin
            e.kind = 2'd2; e.err = 2'b10;
        end else begin
            e.kind = c.op ? 2'd1 : 2'd0;
            e.ab   = c.ab;
            e.a    = (!c.op && c.ab)  ? 5'd0 : c.a;
            e.b    = (!c.op && !c.ab) ? 5'd0 : c.b;
            e.bias = c.bias; e.act = c.act; e.pool = c.pool;
            if (!c.op) begin
                if (c.ab) m_lb[c.b] = 1'b1;
                else      m_la[c.a] = 1'b1;
            end
        end
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.load || bus.multiply) begin
                ev_t e = '0;
                check("strobe_rule", {62'd0, bus.load && bus.multiply, prev_strobe}, 64'd0);
                e.kind = bus.multiply ? 2'd1 : 2'd0;
                e.ab   = bus.buffer_a_b;
                e.a    = bus.buffer_a_idx;
                e.b    = bus.buffer_b_idx;
                e.bias = bus.bias;
                e.act  = bus.activation;
                e.pool = bus.pooling;
                got_q.push_back(e);
            end
            if (bus.cmd_error) begin
                ev_t e = '0;
                e.kind = 2'd2;
                e.err  = bus.err_code;
                got_q.push_back(e);
            end
        end
        prev_strobe = !rst && (bus.load || bus.multiply);
    end

    // MPU: drops ready 0-1 cycles after a strobe, keeps it low 1-3 cycles
    always begin
        @(negedge clk);
        if (auto_mpu && !rst && (bus.load || bus.multiply)) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            mpu_auto_rdy = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            mpu_auto_rdy = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input tcmd_t c, input bit record);
        int t = 0;
        bus.in_op = c.op; bus.in_buffer_a_b = c.ab;
        bus.in_a_idx = c.a; bus.in_b_idx = c.b; bus.in_bias = c.bias;
        bus.in_activation = c.act; bus.in_pooling = c.pool;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 300) begin
            tick();
            t++;
        end
        check("push_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        if (record) model_accept(c);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((bus.busy || !bus.mpu_ready) && t < 1000) begin
            tick();
            t++;
        end
        check("drain_busy", 64'(bus.busy), 64'd0);
        tick();
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            ev_t g = got_q.pop_front();
            ev_t e = exp_q.pop_front();
            check(tag, {9'd0, g}, {9'd0, e});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_clear();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {4'd0, bus.load, bus.multiply, bus.cmd_error, bus.err_code, bus.busy,
                    bus.queue_level, bus.buffer_a_b, bus.buffer_a_idx, bus.buffer_b_idx,
                    bus.bias, bus.activation, bus.pooling}, 64'd0);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_op = 1'b0; bus.in_buffer_a_b = 1'b0;
        bus.in_a_idx = '0; bus.in_b_idx = '0; bus.in_bias = '0;
        bus.in_activation = '0; bus.in_pooling = '0; bus.invalidate = 1'b0;

        // Reset values
        do_reset();
        check_reset_outputs("reset");

        // LOAD A1, LOAD B2, MULTIPLY(1,2,-5) with issue latency
        push(mk(0, 0, 1, 7, 9, 3, 4), 1'b1);
        check("lat_level", 64'(bus.queue_level), 64'd1);
        check("lat_no_strobe", 64'(bus.load), 64'd0);
        tick();
        check("lat_load", 64'({bus.load, bus.buffer_a_idx, bus.buffer_b_idx}), 64'({1'b1, 5'd1, 5'd0}));
        check("lat_level0", 64'(bus.queue_level), 64'd0);
        push(mk(0, 1, 5, 2, 0, 0, 0), 1'b1);
        push(mk(1, 0, 1, 2, -5, 1, 1), 1'b1);
        wait_idle();
        check("mul_hold", 64'({bus.buffer_a_idx, bus.buffer_b_idx, bus.bias}),
              64'({5'd1, 5'd2, 24'hFFFFFB}));
        check("no_err", 64'(bus.err_code), 64'd0);
        compare_events("seq1");

        // MULTIPLY on empty scoreboard
        do_reset();
        push(mk(1, 0, 0, 0, 0, 0, 0), 1'b1);
        tick();
        check("drop_pulse", 64'({bus.cmd_error, bus.err_code, bus.load, bus.multiply}), 64'({1'b1, 2'b10, 2'b00}));
        check("drop_level", 64'(bus.queue_level), 64'd0);
        tick();
        check("drop_hold", 64'({bus.cmd_error, bus.err_code}), 64'({1'b0, 2'b10}));
        compare_events("drop10");

        // Index out of range; aliasing of idx 4 onto 0 must not happen
        push(mk(0, 0, BUF, 0, 0, 0, 0), 1'b1);
        push(mk(1, 0, BUF, 0, 0, 0, 0), 1'b1);
        push(mk(0, 1, 3, 0, 0, 0, 0), 1'b1);
        push(mk(1, 0, 0, 0, 0, 0, 0), 1'b1);
        wait_idle();
        check("range_last_code", 64'(bus.err_code), 64'd2);
        compare_events("range");

        // FIFO full while MPU stalled
        do_reset();
        auto_mpu = 1'b0;
        mpu_man  = 1'b0;
        push(mk(0, 0, 0, 0, 1, 0, 0), 1'b1);
        push(mk(0, 1, 0, 0, 2, 0, 0), 1'b1);
        push(mk(0, 0, 1, 0, 3, 0, 0), 1'b1);
        push(mk(1, 0, 0, 0, 4, 2, 2), 1'b1);
        check("full_level", 64'({bus.queue_level, bus.in_ready}), 64'({3'd4, 1'b0}));
        bus.in_valid = 1'b1;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        check("full_ignored", 64'(bus.queue_level), 64'd4);
        auto_mpu = 1'b1;
        push(mk(1, 0, 1, 0, 5, 0, 0), 1'b1);
        wait_idle();
        compare_events("full");

        // Invalidate clears, and loses against a coincident LOAD issue
        push(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);
        push(mk(0, 1, 0, 0, 0, 0, 0), 1'b1);
        wait_idle();
        bus.invalidate = 1'b1;
        tick();
        bus.invalidate = 1'b0;
        model_clear();
        push(mk(1, 0, 0, 0, 0, 0, 0), 1'b1);
        wait_idle();
        push(mk(0, 0, 3, 0, 0, 0, 0), 1'b1);
        bus.invalidate = 1'b1;
        tick();
        check("coinc_load", 64'(bus.load), 64'd1);
        bus.invalidate = 1'b0;
        model_clear();
        m_la[3] = 1'b1;
        push(mk(0, 1, 0, 1, 0, 0, 0), 1'b1);
        push(mk(1, 0, 3, 1, 77, 5, 6), 1'b1);
        push(mk(1, 0, 0, 1, 0, 0, 0), 1'b1);
        wait_idle();
        compare_events("invalidate");

        // Reset while in WAIT_LOW with two commands queued
        auto_mpu = 1'b0;
        mpu_man  = 1'b1;
        push(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);
        push(mk(0, 0, 1, 0, 0, 0, 0), 1'b0);
        push(mk(0, 0, 2, 0, 0, 0, 0), 1'b0);
        check("pre_rst_level", 64'(bus.queue_level), 64'd2);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        model_clear();
        mpu_man = 1'b0;
        repeat (2) tick();
        mpu_man = 1'b1;
        repeat (6) tick();
        check("post_rst_idle", 64'({bus.busy, bus.queue_level}), 64'd0);
        compare_events("mid_reset");
        auto_mpu = 1'b1;

        // Random traffic
        do_reset();
        for (int i = 0; i < 80; i++) begin
            tcmd_t c;
            c.op   = 1'($urandom_range(0, 1));
            c.ab   = 1'($urandom_range(0, 1));
            c.a    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(BUF, 31)) : 5'($urandom_range(0, BUF - 1));
            c.b    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(BUF, 31)) : 5'($urandom_range(0, BUF - 1));
            c.bias = BW'($urandom);
            c.act  = 8'($urandom);
            c.pool = 8'($urandom);
            push(c, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle();
        compare_events("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
